wb_port_arbiter: RTL and testbench

Write-back arbiter for the integer architectural register file's single write port. Each cycle it selects one of several execution-unit write-back requests (ALU, LSU, MUL/DIV) with round-robin priority. It registers the winner and drives the register file's write-enable, address and data one cycle later. It also counts lost arbitration cycles for performance monitoring, and lets the pipeline flush in-flight write-backs.

---
 rtl/wb_port_arbiter.sv | 114 +++++++++++
 tb/tb_wb_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin write-back arbiter for the integer register file's single write port.
// Optional macro WB_X0_DISCARD_EN: granted writes to x0 are consumed but never written.
module wb_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      flush,
  output logic                      wb_we,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic [DATA_W-1:0]         wb_data,
  output logic [2:0]                wb_src,
  output logic [CNT_W-1:0]          contention_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [PTR_W-1:0]  ptr_p1;
  logic              gnt_any_p0;
  logic [PTR_W-1:0]  gnt_idx_p0;
  logic [ADDR_W-1:0] gnt_addr_p0;
  logic [DATA_W-1:0] gnt_data_p0;
  logic              we_nxt_p0;
  logic              contend_p0;
  int                best_p0;
  int                dist_p0;

  logic              wb_we_p1;
  logic [ADDR_W-1:0] wb_addr_p1;
  logic [DATA_W-1:0] wb_data_p1;
  logic [2:0]        wb_src_p1;
  logic [CNT_W-1:0]  cnt_p1;

  // Stage p0: pick the valid requester closest to ptr in circular order
  always_comb begin
    gnt_any_p0 = 1'b0;
    gnt_idx_p0 = '0;
    best_p0    = NUM_REQ;
    dist_p0    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      dist_p0 = (i >= int'(ptr_p1)) ? i - int'(ptr_p1) : i + NUM_REQ - int'(ptr_p1);
      if (req_valid[i] && (dist_p0 < best_p0)) begin
        best_p0    = dist_p0;
        gnt_idx_p0 = PTR_W'(i);
        gnt_any_p0 = 1'b1;
      end
    end
    if (flush || reset)
      gnt_any_p0 = 1'b0;
  end

  always_comb begin
    req_ready   = '0;
    gnt_addr_p0 = '0;
    gnt_data_p0 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = gnt_any_p0 && (gnt_idx_p0 == PTR_W'(i));
      if (gnt_idx_p0 == PTR_W'(i)) begin
        gnt_addr_p0 = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data_p0 = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
`ifdef WB_X0_DISCARD_EN
    we_nxt_p0 = gnt_any_p0 && (gnt_addr_p0 != '0);
`else
    we_nxt_p0 = gnt_any_p0;
`endif
    contend_p0 = (gnt_any_p0 && ($countones(req_valid) >= 2)) || (flush && (|req_valid));
  end

  // Stage p1: registered write-back beat, pointer and contention counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_p1     <= '0;
      cnt_p1     <= '0;
      wb_we_p1   <= 1'b0;
      wb_addr_p1 <= '0;
      wb_data_p1 <= '0;
      wb_src_p1  <= '0;
    end else begin
      wb_we_p1 <= we_nxt_p0;
      if (gnt_any_p0)
        ptr_p1 <= (gnt_idx_p0 == PTR_W'(NUM_REQ-1)) ? '0 : gnt_idx_p0 + 1'b1;
      if (we_nxt_p0) begin
        wb_addr_p1 <= gnt_addr_p0;
        wb_data_p1 <= gnt_data_p0;
        wb_src_p1  <= 3'(gnt_idx_p0);
      end
      if (contend_p0)
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign wb_we          = wb_we_p1;
  assign wb_addr        = wb_addr_p1;
  assign wb_data        = wb_data_p1;
  assign wb_src         = wb_src_p1;
  assign contention_cnt = cnt_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// compared against a queue-free behavioural round-robin model.
module tb_wb_port_arbiter;
  localparam int N    = 3;
  localparam int A    = 5;
  localparam int D    = 32;
  localparam int C    = 4;
  localparam int CMAX = (1 << C) - 1;

  logic           clk;
  logic           reset;
  logic           flush;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_data;
  logic           wb_we;
  logic [A-1:0]   wb_addr;
  logic [D-1:0]   wb_data;
  logic [2:0]     wb_src;
  logic [C-1:0]   contention_cnt;

  logic         t_valid[N];
  logic [A-1:0] t_addr[N];
  logic [D-1:0] t_data[N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_valid[gi]          = t_valid[gi];
    assign req_addr[gi*A +: A]    = t_addr[gi];
    assign req_data[gi*D +: D]    = t_data[gi];
  end

  wb_port_arbiter #(.NUM_REQ(N), .DATA_W(D), .ADDR_W(A), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .flush(flush), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_src(wb_src),
    .contention_cnt(contention_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_ptr;
  int           m_cnt;
  int           m_src;
  logic         m_we;
  logic [A-1:0] m_addr;
  logic [D-1:0] m_data;

  function automatic int model_grant();
    int idx;
    if (reset || flush) return -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (t_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] one;
    int g;
    one = 1;
    g = model_grant();
    return (g >= 0) ? (one << g) : '0;
  endfunction

  // Advance model and DUT by one clock; the granted request is retired.
  task automatic tick();
    int g;
    int pop;
    logic write;
    g = model_grant();
    pop = 0;
    for (int i = 0; i < N; i++) if (t_valid[i]) pop++;
    if (reset) begin
      m_we = 0; m_addr = '0; m_data = '0; m_src = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (((pop >= 2) && (g >= 0)) || (flush && (pop > 0)))
        if (m_cnt < CMAX) m_cnt++;
      m_we = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
`ifdef WB_X0_DISCARD_EN
        write = (t_addr[g] != '0);
`else
        write = 1'b1;
`endif
        if (write) begin
          m_we = 1; m_addr = t_addr[g]; m_data = t_data[g]; m_src = g;
        end
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) t_valid[g] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [A-1:0] a, input logic [D-1:0] d);
    t_valid[i] = v; t_addr[i] = a; t_data[i] = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, A'(i + 1), $urandom);
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL reset_ready got %b want 000", req_ready);
    end
    tick();
    checks++;
    if ({wb_we, wb_addr, wb_data, wb_src} !== '0) begin
      errors++; $display("FAIL reset_outputs got we=%b addr=%0d data=%h src=%0d want all zero",
                         wb_we, wb_addr, wb_data, wb_src);
    end
    checks++;
    if (contention_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", contention_cnt);
    end
    reset = 1'b0;
    clear_all();
  endtask

  task automatic test_single();
    clear_all();
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL single_ready got %b want 001", req_ready);
    end
    tick();
    checks++;
    if ({wb_we, wb_addr, wb_data, wb_src} !== {1'b1, 5'd5, 32'hDEADBEEF, 3'd0}) begin
      errors++; $display("FAIL single_beat got we=%b addr=%0d data=%h src=%0d want 1 5 deadbeef 0",
                         wb_we, wb_addr, wb_data, wb_src);
    end
    tick();
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      errors++; $display("FAIL single_drain got we=%b addr=%0d data=%h want 0 5 deadbeef (held)",
                         wb_we, wb_addr, wb_data);
    end
  endtask

  task automatic test_fairness();
    logic [2:0] pats[6];
    int exp_g[6];
    logic [N-1:0] one;
    one = 1;
    pats[0] = 3'b111; pats[1] = 3'b111; pats[2] = 3'b111;
    pats[3] = 3'b011; pats[4] = 3'b010; pats[5] = 3'b100;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 0; exp_g[4] = 1; exp_g[5] = 2;
    clear_all();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++)
        set_req(i, pats[c][i], A'($urandom_range(1, 31)), $urandom);
      #1;
      checks++;
      if (req_ready !== (one << exp_g[c])) begin
        errors++; $display("FAIL fair_ready cycle %0d got %b want %b", c, req_ready, one << exp_g[c]);
      end
      tick();
      checks++;
      if ({wb_we, wb_src} !== {1'b1, 3'(exp_g[c])}) begin
        errors++; $display("FAIL fair_src cycle %0d got we=%b src=%0d want 1 %0d", c, wb_we, wb_src, exp_g[c]);
      end
    end
    checks++;
    if (contention_cnt !== 4'd4) begin
      errors++; $display("FAIL fair_cnt got %0d want 4", contention_cnt);
    end
    clear_all();
  endtask

  task automatic test_collision();
    clear_all();
    set_req(0, 1'b1, 5'd3, 32'd9);
    tick();
    set_req(1, 1'b1, 5'd10, 32'd1);
    set_req(2, 1'b1, 5'd10, 32'd2);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL coll_ready1 got %b want 010", req_ready);
    end
    tick();
    checks++;
    if ({wb_we, wb_addr, wb_data, wb_src} !== {1'b1, 5'd10, 32'd1, 3'd1}) begin
      errors++; $display("FAIL coll_beat1 got we=%b addr=%0d data=%0d src=%0d want 1 10 1 1",
                         wb_we, wb_addr, wb_data, wb_src);
    end
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL coll_ready2 got %b want 100", req_ready);
    end
    tick();
    checks++;
    if ({wb_we, wb_addr, wb_data, wb_src} !== {1'b1, 5'd10, 32'd2, 3'd2}) begin
      errors++; $display("FAIL coll_beat2 got we=%b addr=%0d data=%0d src=%0d want 1 10 2 2",
                         wb_we, wb_addr, wb_data, wb_src);
    end
  endtask

  task automatic test_flush();
    int exp_cnt;
    clear_all();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, A'($urandom_range(1, 31)), $urandom);
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL flush_ready got %b want 000", req_ready);
    end
    exp_cnt = m_cnt + 1;
    tick();
    flush = 1'b0;
    checks++;
    if (wb_we !== 1'b0) begin
      errors++; $display("FAIL flush_we got %b want 0", wb_we);
    end
    checks++;
    if (int'(contention_cnt) != exp_cnt) begin
      errors++; $display("FAIL flush_cnt got %0d want %0d", contention_cnt, exp_cnt);
    end
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL flush_resume got %b want 001", req_ready);
    end
    tick();
    checks++;
    if ({wb_we, wb_src} !== {1'b1, 3'd0}) begin
      errors++; $display("FAIL flush_resume_src got we=%b src=%0d want 1 0", wb_we, wb_src);
    end
    clear_all();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) if (!t_valid[i]) set_req(i, 1'b1, A'($urandom_range(1, 31)), $urandom);
      tick();
    end
    for (int i = 0; i < N; i++) if (!t_valid[i]) set_req(i, 1'b1, A'($urandom_range(1, 31)), $urandom);
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL rstmid_ready got %b want 000", req_ready);
    end
    tick();
    reset = 1'b0;
    checks++;
    if ({wb_we, wb_src, contention_cnt} !== '0) begin
      errors++; $display("FAIL rstmid_out got we=%b src=%0d cnt=%0d want 0 0 0", wb_we, wb_src, contention_cnt);
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b1, A'($urandom_range(1, 31)), $urandom);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL rstmid_first got %b want 001", req_ready);
    end
    clear_all();
  endtask

  task automatic test_x0();
    clear_all();
    set_req(0, 1'b1, 5'd0, 32'd7);
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL x0_ready got %b want 001", req_ready);
    end
    tick();
`ifdef WB_X0_DISCARD_EN
    checks++;
    if (wb_we !== 1'b0) begin
      errors++; $display("FAIL x0_we got %b want 0", wb_we);
    end
`else
    checks++;
    if ({wb_we, wb_addr, wb_data} !== {1'b1, 5'd0, 32'd7}) begin
      errors++; $display("FAIL x0_pass got we=%b addr=%0d data=%0d want 1 0 7", wb_we, wb_addr, wb_data);
    end
`endif
    set_req(0, 1'b1, 5'd4, 32'd8);
    set_req(1, 1'b1, 5'd6, 32'd9);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL x0_ptr got %b want 010", req_ready);
    end
    clear_all();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) if (!t_valid[i]) set_req(i, 1'b1, A'($urandom_range(1, 31)), $urandom);
      tick();
      checks++;
      if (int'(contention_cnt) != m_cnt) begin
        errors++; $display("FAIL sat_cnt cycle %0d got %0d want %0d", c, contention_cnt, m_cnt);
      end
    end
    checks++;
    if (contention_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_final got %0d want 15", contention_cnt);
    end
    clear_all();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!t_valid[i] && ($urandom_range(0, 1) == 1))
          set_req(i, 1'b1, A'($urandom), $urandom);
      flush = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 49) == 0);
      #1;
      checks++;
      if (req_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready cycle %0d got %b want %b", c, req_ready, model_ready());
      end
      tick();
      checks++;
      if ({wb_we, wb_addr, wb_data, wb_src, contention_cnt} !== {m_we, m_addr, m_data, 3'(m_src), C'(m_cnt)}) begin
        errors++; $display("FAIL rand_out cycle %0d got we=%b addr=%0d data=%h src=%0d cnt=%0d want %b %0d %h %0d %0d",
                           c, wb_we, wb_addr, wb_data, wb_src, contention_cnt, m_we, m_addr, m_data, m_src, m_cnt);
      end
    end
    reset = 1'b0;
    flush = 1'b0;
    clear_all();
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_all();
    #2;
    test_reset();
    test_single();
    test_fairness();
    test_collision();
    test_flush();
    test_reset_mid();
    test_x0();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
